// File: rtl/sgd_axb_a_dispatch.sv
// sgd_axb_a_dispatch
// Transmitter side of the per-engine A-matrix dispatch interface. Takes the
// linear stream of 512-bit bit-sliced A lines from the HBM read path and routes
// each line through a 2-entry per-engine FIFO to its owning engine.
// Optional feature macro: SGD_DISPATCH_STALL_CNT_EN (adds the stall_cnt output).
module sgd_axb_a_dispatch #(
  parameter int ENGINE_NUM         = 2,
  parameter int NUM_BITS_PER_BANK  = 64,
  parameter int NUM_OF_BANKS       = 8,
  parameter int MAX_DIMENSION_BITS = 18
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         start,
  input  logic [31:0]                  dimension,
  input  logic [31:0]                  number_of_samples,
  input  logic [31:0]                  number_of_bits,
  input  logic [31:0]                  number_of_epochs,
  input  logic [511:0]                 mem_rd_data,
  input  logic                         mem_rd_valid,
  output logic                         mem_rd_ready,
  output logic [ENGINE_NUM-1:0][511:0] dispatch_axb_a_data,
  output logic [ENGINE_NUM-1:0]        dispatch_axb_a_wr_en,
  input  logic [ENGINE_NUM-1:0]        dispatch_axb_a_almost_full,
  output logic                         done,
  output logic                         busy
`ifdef SGD_DISPATCH_STALL_CNT_EN
  ,
  output logic [31:0]                  stall_cnt
`endif
);

  localparam int ENG_W = (ENGINE_NUM > 1) ? $clog2(ENGINE_NUM) : 1;
  localparam logic [ENG_W-1:0] ENG_LAST = ENG_W'(ENGINE_NUM - 1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_RUN   = 2'd1,
    S_DRAIN = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  state_t                          state_q;
  logic                            start_q;
  logic                            done_q;
  logic                            busy_q;

  // Latched run configuration (lines per plane group etc.)
  logic [31:0]                     bits_q;
  logic [31:0]                     groups_q;
  logic [31:0]                     epochs_q;
  logic [MAX_DIMENSION_BITS-1:0]   chunks_q;

  // Position of the next line to be accepted in memory order
  logic [31:0]                     bit_cnt_q;
  logic [MAX_DIMENSION_BITS-1:0]   chunk_cnt_q;
  logic [31:0]                     group_cnt_q;
  logic [31:0]                     epoch_cnt_q;
  logic [ENG_W-1:0]                eng_q;

  // Per-engine 2-entry FIFOs and registered dispatch outputs
  logic [ENGINE_NUM-1:0][1:0][511:0] fifo_mem_q;
  logic [ENGINE_NUM-1:0]             wr_ptr_q;
  logic [ENGINE_NUM-1:0]             rd_ptr_q;
  logic [ENGINE_NUM-1:0][1:0]        cnt_q;
  logic [ENGINE_NUM-1:0][1:0]        cnt_d;
  logic [ENGINE_NUM-1:0][511:0]      data_q;
  logic [ENGINE_NUM-1:0]             wr_en_q;

  logic                            start_rise_s;
  logic                            accept_s;
  logic                            run_empty_s;
  logic [1:0]                      tgt_cnt_s;
  logic                            bit_last_s;
  logic                            chunk_last_s;
  logic                            group_last_s;
  logic                            epoch_last_s;
  logic                            final_line_s;
  logic                            fifos_idle_s;
  logic                            cfg_zero_s;
  logic [ENGINE_NUM-1:0]           push_s;
  logic [ENGINE_NUM-1:0]           pop_s;

  assign start_rise_s = start & ~start_q;
  assign cfg_zero_s   = (dimension == 32'd0) || (number_of_samples == 32'd0) ||
                        (number_of_bits == 32'd0) || (number_of_epochs == 32'd0);
  // A configuration too small to form a single line group requests nothing.
  assign run_empty_s  = (chunks_q == {MAX_DIMENSION_BITS{1'b0}}) || (groups_q == 32'd0);
  assign tgt_cnt_s    = cnt_q[eng_q];
  // Ready depends only on state and the target FIFO fill, never on valid.
  assign mem_rd_ready = (state_q == S_RUN) && !run_empty_s && (tgt_cnt_s < 2'd2);
  assign accept_s     = mem_rd_valid & mem_rd_ready;

  assign bit_last_s   = (bit_cnt_q == bits_q - 32'd1);
  assign chunk_last_s = (chunk_cnt_q == chunks_q - MAX_DIMENSION_BITS'(1));
  assign group_last_s = (group_cnt_q == groups_q - 32'd1);
  assign epoch_last_s = ((epoch_cnt_q + 32'd1) >= epochs_q);
  assign final_line_s = accept_s & bit_last_s & chunk_last_s & group_last_s & epoch_last_s;

  // Per-engine push/pop decisions and next fill level.
  always_comb begin
    push_s       = {ENGINE_NUM{1'b0}};
    pop_s        = {ENGINE_NUM{1'b0}};
    cnt_d        = cnt_q;
    fifos_idle_s = (wr_en_q == {ENGINE_NUM{1'b0}});
    for (int e = 0; e < ENGINE_NUM; e++) begin
      push_s[e]    = accept_s & (eng_q == ENG_W'(e));
      pop_s[e]     = (cnt_q[e] != 2'd0) & ~dispatch_axb_a_almost_full[e];
      cnt_d[e]     = cnt_q[e] + {1'b0, push_s[e]} - {1'b0, pop_s[e]};
      fifos_idle_s = fifos_idle_s & (cnt_q[e] == 2'd0);
    end
  end

  // Control FSM: configuration latch, memory-order counters, done/busy.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= S_IDLE;
      start_q     <= 1'b0;
      done_q      <= 1'b0;
      busy_q      <= 1'b0;
      bits_q      <= 32'd0;
      groups_q    <= 32'd0;
      epochs_q    <= 32'd0;
      chunks_q    <= {MAX_DIMENSION_BITS{1'b0}};
      bit_cnt_q   <= 32'd0;
      chunk_cnt_q <= {MAX_DIMENSION_BITS{1'b0}};
      group_cnt_q <= 32'd0;
      epoch_cnt_q <= 32'd0;
      eng_q       <= {ENG_W{1'b0}};
    end else begin
      start_q <= start;
      case (state_q)
        S_IDLE: begin
          done_q <= 1'b0;
          if (start_rise_s) begin
            bits_q      <= number_of_bits;
            groups_q    <= number_of_samples / 32'(NUM_OF_BANKS);
            epochs_q    <= number_of_epochs;
            chunks_q    <= MAX_DIMENSION_BITS'(dimension / 32'(NUM_BITS_PER_BANK));
            bit_cnt_q   <= 32'd0;
            chunk_cnt_q <= {MAX_DIMENSION_BITS{1'b0}};
            group_cnt_q <= 32'd0;
            epoch_cnt_q <= 32'd0;
            eng_q       <= {ENG_W{1'b0}};
            busy_q      <= 1'b1;
            if (cfg_zero_s) begin
              state_q <= S_DONE;
              done_q  <= 1'b1;
            end else begin
              state_q <= S_RUN;
            end
          end
        end
        S_RUN: begin
          if (run_empty_s) begin
            state_q <= S_DRAIN;
          end else if (accept_s) begin
            if (bit_last_s) begin
              bit_cnt_q <= 32'd0;
              if (chunk_last_s) begin
                // New sample group (or epoch): engine index restarts at 0.
                chunk_cnt_q <= {MAX_DIMENSION_BITS{1'b0}};
                eng_q       <= {ENG_W{1'b0}};
                if (group_last_s) begin
                  group_cnt_q <= 32'd0;
                  epoch_cnt_q <= epoch_cnt_q + 32'd1;
                end else begin
                  group_cnt_q <= group_cnt_q + 32'd1;
                end
              end else begin
                chunk_cnt_q <= chunk_cnt_q + MAX_DIMENSION_BITS'(1);
                eng_q       <= (eng_q == ENG_LAST) ? {ENG_W{1'b0}} : eng_q + ENG_W'(1);
              end
            end else begin
              bit_cnt_q <= bit_cnt_q + 32'd1;
            end
            if (final_line_s) begin
              state_q <= S_DRAIN;
            end
          end
        end
        S_DRAIN: begin
          if (fifos_idle_s) begin
            state_q <= S_DONE;
            done_q  <= 1'b1;
          end
        end
        S_DONE: begin
          done_q  <= 1'b0;
          busy_q  <= 1'b0;
          state_q <= S_IDLE;
        end
        default: begin
          done_q  <= 1'b0;
          busy_q  <= 1'b0;
          state_q <= S_IDLE;
        end
      endcase
    end
  end

  // Per-engine FIFO storage, pointers and registered write strobe/data.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fifo_mem_q <= '0;
      wr_ptr_q   <= {ENGINE_NUM{1'b0}};
      rd_ptr_q   <= {ENGINE_NUM{1'b0}};
      cnt_q      <= '0;
      data_q     <= '0;
      wr_en_q    <= {ENGINE_NUM{1'b0}};
    end else begin
      for (int e = 0; e < ENGINE_NUM; e++) begin
        if (push_s[e]) begin
          fifo_mem_q[e][wr_ptr_q[e]] <= mem_rd_data;
          wr_ptr_q[e]                <= ~wr_ptr_q[e];
        end
        if (pop_s[e]) begin
          data_q[e]   <= fifo_mem_q[e][rd_ptr_q[e]];
          rd_ptr_q[e] <= ~rd_ptr_q[e];
        end
        cnt_q[e]   <= cnt_d[e];
        wr_en_q[e] <= pop_s[e];
      end
    end
  end

  assign dispatch_axb_a_data  = data_q;
  assign dispatch_axb_a_wr_en = wr_en_q;
  assign done                 = done_q;
  assign busy                 = busy_q;

`ifdef SGD_DISPATCH_STALL_CNT_EN
  logic [31:0] stall_cnt_q;

  // Saturating count of RUN cycles where a valid line is held off.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stall_cnt_q <= 32'd0;
    end else if (start_rise_s) begin
      stall_cnt_q <= 32'd0;
    end else if ((state_q == S_RUN) && mem_rd_valid && !mem_rd_ready &&
                 (stall_cnt_q != 32'hFFFF_FFFF)) begin
      stall_cnt_q <= stall_cnt_q + 32'd1;
    end
  end

  assign stall_cnt = stall_cnt_q;
`endif

endmodule

// File: tb/tb_sgd_axb_a_dispatch.sv
// Self-checking bench for sgd_axb_a_dispatch: per-engine scoreboards of
// expected lines, filled on accept and drained on each dispatch write strobe.
module tb_sgd_axb_a_dispatch;

  localparam int EN = 2;

  logic               clk = 1'b0;
  logic               rst;
  logic               start;
  logic [31:0]        dimension;
  logic [31:0]        number_of_samples;
  logic [31:0]        number_of_bits;
  logic [31:0]        number_of_epochs;
  logic [511:0]       mem_rd_data;
  logic               mem_rd_valid;
  logic               mem_rd_ready;
  logic [EN-1:0][511:0] dispatch_axb_a_data;
  logic [EN-1:0]      dispatch_axb_a_wr_en;
  logic [EN-1:0]      dispatch_axb_a_almost_full;
  logic               done;
  logic               busy;
`ifdef SGD_DISPATCH_STALL_CNT_EN
  logic [31:0]        stall_cnt;
`endif

  int checks   = 0;
  int failures = 0;

  logic [511:0] exp_q0[$];
  logic [511:0] exp_q1[$];

  sgd_axb_a_dispatch #(
    .ENGINE_NUM(EN), .NUM_BITS_PER_BANK(64), .NUM_OF_BANKS(8), .MAX_DIMENSION_BITS(18)
  ) dut (
    .clk(clk),
    .rst(rst),
    .start(start),
    .dimension(dimension),
    .number_of_samples(number_of_samples),
    .number_of_bits(number_of_bits),
    .number_of_epochs(number_of_epochs),
    .mem_rd_data(mem_rd_data),
    .mem_rd_valid(mem_rd_valid),
    .mem_rd_ready(mem_rd_ready),
    .dispatch_axb_a_data(dispatch_axb_a_data),
    .dispatch_axb_a_wr_en(dispatch_axb_a_wr_en),
    .dispatch_axb_a_almost_full(dispatch_axb_a_almost_full),
    .done(done),
    .busy(busy)
`ifdef SGD_DISPATCH_STALL_CNT_EN
    ,
    .stall_cnt(stall_cnt)
`endif
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [511:0] obs, input logic [511:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $display("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      $error("check %s did not hold", tag);
    end
  endtask

  function automatic logic [511:0] line_pat(input int n, input int salt);
    logic [511:0] p;
    for (int w = 0; w < 16; w++) p[w*32 +: 32] = 32'(salt * 65536 + n * 16 + w);
    return p;
  endfunction

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_ready"}, 512'(mem_rd_ready), 512'd0);
    chk({tag, "_wr_en"}, 512'(dispatch_axb_a_wr_en), 512'd0);
    chk({tag, "_data0"}, dispatch_axb_a_data[0], 512'd0);
    chk({tag, "_data1"}, dispatch_axb_a_data[1], 512'd0);
    chk({tag, "_done"}, 512'(done), 512'd0);
    chk({tag, "_busy"}, 512'(busy), 512'd0);
  endtask

  // One run: start pulse, line source, almost_full shaping, scoreboard checks.
  task automatic run_scenario(input string name, input int dim, input int smp, input int bits,
                              input int ep, input int af_eng, input int af_line, input int af_len,
                              input int rst_line, input int exp_wr0, input int exp_wr1,
                              input int salt);
    int T, Lp, per_grp, n, done_cnt, done_cyc, last_wr_cyc, wr0, wr1, af_left, stall_bench, tail, eng;
    bit af_started, ready_seen, aborted;
    logic [511:0] e_data;
    Lp = (smp / 8) * (dim / 64) * bits;
    T = Lp * ep;
    per_grp = (dim / 64) * bits;
    exp_q0.delete();
    exp_q1.delete();
    n = 0; done_cnt = 0; done_cyc = 0; last_wr_cyc = 0; wr0 = 0; wr1 = 0;
    af_left = 0; stall_bench = 0; tail = 0;
    af_started = 1'b0; ready_seen = 1'b0; aborted = 1'b0;

    @(negedge clk);
    dimension = 32'(dim); number_of_samples = 32'(smp);
    number_of_bits = 32'(bits); number_of_epochs = 32'(ep);
    start = 1'b1; mem_rd_valid = 1'b0; dispatch_axb_a_almost_full = '0;

    for (int cyc = 1; cyc <= 4000; cyc++) begin
      @(negedge clk);
      if (dispatch_axb_a_wr_en[0]) begin
        wr0++; last_wr_cyc = cyc;
        chk({name, "_af0_honoured"}, 512'(dispatch_axb_a_almost_full[0]), 512'd0);
        if (exp_q0.size() == 0) chk({name, "_e0_unexpected_wr"}, 512'd1, 512'd0);
        else begin e_data = exp_q0.pop_front(); chk({name, "_e0_data"}, dispatch_axb_a_data[0], e_data); end
      end
      if (dispatch_axb_a_wr_en[1]) begin
        wr1++; last_wr_cyc = cyc;
        chk({name, "_af1_honoured"}, 512'(dispatch_axb_a_almost_full[1]), 512'd0);
        if (exp_q1.size() == 0) chk({name, "_e1_unexpected_wr"}, 512'd1, 512'd0);
        else begin e_data = exp_q1.pop_front(); chk({name, "_e1_data"}, dispatch_axb_a_data[1], e_data); end
      end
      if (done) begin done_cnt++; done_cyc = cyc; end
      if (cyc == 1) chk({name, "_busy_after_start"}, 512'(busy), 512'd1);
      if (cyc == 3) start = 1'b0;
      if (rst_line >= 0 && n == rst_line) begin
        rst = 1'b1;
        #1;
        check_reset_outputs({name, "_midrun_rst"});
        aborted = 1'b1;
        break;
      end
      if (done_cnt > 0) begin
        tail++;
        if (tail > 3) break;
      end
      if (!af_started && af_len > 0 && n >= af_line) begin
        af_started = 1'b1; af_left = af_len;
      end
      if (af_left > 0) begin
        dispatch_axb_a_almost_full = '0;
        dispatch_axb_a_almost_full[af_eng] = 1'b1;
        af_left--;
      end else begin
        dispatch_axb_a_almost_full = '0;
      end
      mem_rd_valid = (n < T);
      mem_rd_data = line_pat(n, salt);
      #1;
      if (mem_rd_ready) ready_seen = 1'b1;
      if (mem_rd_valid && !mem_rd_ready) stall_bench++;
      if (mem_rd_valid && mem_rd_ready) begin
        eng = (((n % Lp) % per_grp) / bits) % 2;
        if (eng == 0) exp_q0.push_back(mem_rd_data);
        else exp_q1.push_back(mem_rd_data);
        n++;
      end
    end
    mem_rd_valid = 1'b0;
    dispatch_axb_a_almost_full = '0;

    if (aborted) begin
      start = 1'b0;
      repeat (3) @(negedge clk);
      check_reset_outputs({name, "_held_rst"});
      rst = 1'b0;
      repeat (2) @(negedge clk);
      chk({name, "_no_done_after_abort"}, 512'(done), 512'd0);
    end else begin
      chk({name, "_done_pulses"}, 512'(done_cnt), 512'd1);
      chk({name, "_lines_accepted"}, 512'(n), 512'(T));
      chk({name, "_wr_count_e0"}, 512'(wr0), 512'(exp_wr0));
      chk({name, "_wr_count_e1"}, 512'(wr1), 512'(exp_wr1));
      chk({name, "_scoreboard_empty"}, 512'(exp_q0.size() + exp_q1.size()), 512'd0);
      chk({name, "_busy_end"}, 512'(busy), 512'd0);
      if (T == 0) begin
        chk({name, "_ready_never"}, 512'(ready_seen), 512'd0);
        chk({name, "_done_within_2"}, 512'(done_cyc >= 1 && done_cyc <= 2), 512'd1);
      end else begin
        chk({name, "_done_latency"},
            512'((done_cyc - last_wr_cyc) >= 1 && (done_cyc - last_wr_cyc) <= 2), 512'd1);
      end
      if (af_len > 0) chk({name, "_backpressure_seen"}, 512'(stall_bench > 0), 512'd1);
`ifdef SGD_DISPATCH_STALL_CNT_EN
      chk({name, "_stall_cnt"}, 512'(stall_cnt), 512'(stall_bench));
`endif
    end
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; mem_rd_valid = 1'b0; mem_rd_data = '0;
    dimension = 32'd0; number_of_samples = 32'd0; number_of_bits = 32'd0; number_of_epochs = 32'd0;
    dispatch_axb_a_almost_full = '0;
    repeat (3) @(negedge clk);
    check_reset_outputs("por");
    rst = 1'b0;
    repeat (2) @(negedge clk);

    run_scenario("base",   256, 16, 8, 1, 0, 0, 0, -1, 32, 32, 1);
    run_scenario("af1",    256, 16, 8, 1, 1, 10, 50, -1, 32, 32, 2);
    run_scenario("epoch3", 256, 16, 8, 3, 0, 0, 0, -1, 96, 96, 3);
    run_scenario("zbits",  256, 16, 0, 1, 0, 0, 0, -1, 0, 0, 4);
    run_scenario("rst20",  256, 16, 8, 1, 0, 0, 0, 20, 0, 0, 5);
    run_scenario("replay", 256, 16, 8, 1, 0, 0, 0, -1, 32, 32, 6);
`ifdef SGD_DISPATCH_STALL_CNT_EN
    run_scenario("stall0", 256, 16, 8, 1, 0, 0, 30, -1, 32, 32, 7);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
